bram_arbiter: RTL

- Two-port round-robin arbiter sharing one single-port-per-cycle init_bram instance between two requesters, e.g. the CPU data port (port 0) and the loader/DMA port (port 1).
- Accepts at most one read or write per cycle and drives the BRAM's write/read strobes, addresses and write data.
- Routes the one-cycle-latency read data back to the requester that issued the read, with a valid strobe.

---
 rtl/bram_arbiter_if.sv | 23 ++
 rtl/bram_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/bram_arbiter_if.sv
// Requester-side bundle for bram_arbiter: request/command inputs, grant and read-return outputs.
// The lock signal exists only when BRAM_ARB_LOCK_EN is defined.
interface bram_arbiter_if #(
  parameter int memSize_p   = 8,
  parameter int dataWidth_p = 16
);
  logic                   req;
  logic                   we;
  logic [memSize_p-1:0]   addr;
  logic [dataWidth_p-1:0] wdata;
  logic                   gnt;
  logic                   rvalid;
  logic [dataWidth_p-1:0] rdata;
`ifdef BRAM_ARB_LOCK_EN
  logic                   lock;

  modport master (output req, we, addr, wdata, lock, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, lock, output gnt, rvalid, rdata);
`else
  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
`endif
endinterface

// File: rtl/bram_arbiter.sv
// Round-robin arbiter sharing one registered-read BRAM between two requesters.
// Optional burst locking is enabled by defining BRAM_ARB_LOCK_EN.
module bram_arbiter #(
  parameter int memSize_p   = 8,
  parameter int dataWidth_p = 16,
  parameter int lockMax_p   = 15
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  bram_arbiter_if.slave          port0,
  bram_arbiter_if.slave          port1,
  output logic                   mem_write_o,
  output logic                   mem_read_o,
  output logic [memSize_p-1:0]   mem_waddr_o,
  output logic [memSize_p-1:0]   mem_raddr_o,
  output logic [dataWidth_p-1:0] mem_wdata_o,
  input  logic [dataWidth_p-1:0] mem_rdata_i
);

  if (lockMax_p < 1 || lockMax_p > 15) begin : g_bad_lock_max
    $error("bram_arbiter: lockMax_p must be in 1..15");
  end

`ifdef BRAM_ARB_LOCK_EN
  typedef enum logic [1:0] {PRI0, PRI1, LOCK0, LOCK1} state_t;
  localparam logic [3:0] LockMax = 4'(lockMax_p);

  logic [3:0] cnt;
  logic [3:0] cnt_inc;
  logic       locked0;
  logic       locked1;
`else
  typedef enum logic {PRI0, PRI1} state_t;
`endif

  state_t                 state;
  logic                   gnt0;
  logic                   gnt1;
  logic                   win_we;
  logic [memSize_p-1:0]   win_addr;
  logic [dataWidth_p-1:0] win_wdata;
  logic                   pending;
  logic                   rd_owner;
  logic [dataWidth_p-1:0] rdata0_q;
  logic [dataWidth_p-1:0] rdata1_q;
  logic                   ret0;
  logic                   ret1;

`ifdef BRAM_ARB_LOCK_EN
  // A lock gives way once its counter is spent and the other port is waiting,
  // or as soon as the owner drops its lock line.
  assign locked0 = (state == LOCK0) && port0.lock && !((cnt == LockMax) && port1.req);
  assign locked1 = (state == LOCK1) && port1.lock && !((cnt == LockMax) && port0.req);
  assign cnt_inc = (cnt == LockMax) ? cnt : cnt + 4'd1;
`endif

  // NOTE: every signal assigned here gets a default first, so no latch is inferred.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_ni) begin
`ifdef BRAM_ARB_LOCK_EN
      if (locked0) begin
        gnt0 = port0.req;
      end else if (locked1) begin
        gnt1 = port1.req;
      end else begin
        // A released LOCK0 behaves like PRI1, a released LOCK1 like PRI0.
        gnt1 = port1.req && (!port0.req || state == PRI1 || state == LOCK0);
        gnt0 = port0.req && !gnt1;
      end
`else
      gnt1 = port1.req && (!port0.req || state == PRI1);
      gnt0 = port0.req && !gnt1;
`endif
    end
  end

  assign port0.gnt = gnt0;
  assign port1.gnt = gnt1;

  // Address and data always follow the winner; they are ignored when no strobe is up.
  assign win_we    = gnt1 ? port1.we    : port0.we;
  assign win_addr  = gnt1 ? port1.addr  : port0.addr;
  assign win_wdata = gnt1 ? port1.wdata : port0.wdata;

  assign mem_write_o = (gnt0 || gnt1) && win_we;
  assign mem_read_o  = (gnt0 || gnt1) && !win_we;
  assign mem_waddr_o = win_addr;
  assign mem_raddr_o = win_addr;
  assign mem_wdata_o = win_wdata;

  // Read data is live from the BRAM in the return cycle, then held per port.
  assign ret0 = pending && !rd_owner;
  assign ret1 = pending &&  rd_owner;

  assign port0.rvalid = ret0;
  assign port1.rvalid = ret1;
  assign port0.rdata  = ret0 ? mem_rdata_i : rdata0_q;
  assign port1.rdata  = ret1 ? mem_rdata_i : rdata1_q;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= PRI0;
      pending  <= 1'b0;
      rd_owner <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
`ifdef BRAM_ARB_LOCK_EN
      cnt      <= 4'd0;
`endif
    end else begin
      pending <= mem_read_o;
      if (mem_read_o) rd_owner <= gnt1;
      if (ret0) rdata0_q <= mem_rdata_i;
      if (ret1) rdata1_q <= mem_rdata_i;

`ifdef BRAM_ARB_LOCK_EN
      if (locked0) begin
        if (gnt0) cnt <= cnt_inc;
      end else if (locked1) begin
        if (gnt1) cnt <= cnt_inc;
      end else if (gnt0) begin
        if (port0.lock) begin
          state <= LOCK0;
          cnt   <= 4'd1;
        end else begin
          state <= PRI1;
        end
      end else if (gnt1) begin
        if (port1.lock) begin
          state <= LOCK1;
          cnt   <= 4'd1;
        end else begin
          state <= PRI0;
        end
      end else if (state == LOCK0) begin
        state <= PRI1;
      end else if (state == LOCK1) begin
        state <= PRI0;
      end
`else
      if (gnt0)      state <= PRI1;
      else if (gnt1) state <= PRI0;
`endif
    end
  end

endmodule
